// File: rtl/pstats_evt_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pstats_evt_buffer                                               |
// | Purpose  : Buffers one-cycle event pulses in per-event 2-bit saturating    |
// |            pending counters. A round-robin scanner offers one word of      |
// |            pending-event flags at a time over a valid/ready handshake.     |
// |            Sticky per-event overflow flags record lost events.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pstats_evt_buffer #(
  parameter  int g_cnt_pp = 64,
  parameter  int g_word_w = 16,
  localparam int c_nwords = g_cnt_pp / g_word_w,
  localparam int c_idx_w  = (c_nwords > 1) ? $clog2(c_nwords) : 1
) (
  input  logic                rst_n_i,
  input  logic                clk_i,
  input  logic [g_cnt_pp-1:0] events_i,
  output logic [g_word_w-1:0] evt_o,
  output logic [c_idx_w-1:0]  evt_idx_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [g_cnt_pp-1:0] ovf_o,
  input  logic                ovf_clr_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_OFFER = 2'd2
  } state_t;

  state_t              state_q;
  logic [c_idx_w-1:0]  ptr_q;
  logic [g_word_w-1:0] evt_q;
  logic [c_idx_w-1:0]  evt_idx_q;
  logic                valid_q;

  logic [g_cnt_pp-1:0] w_nz;
  logic [g_cnt_pp-1:0] w_ovf;
  logic [g_word_w-1:0] w_scan_word;
  logic [c_idx_w-1:0]  w_ptr_nxt;
  logic                w_any;
  logic                w_hs;

  assign w_any     = |w_nz;
  assign w_hs      = valid_q & evt_ready_i;
  assign w_ptr_nxt = (ptr_q == c_idx_w'(c_nwords - 1)) ? '0 : ptr_q + c_idx_w'(1);

  // Per-event pending counter and sticky overflow flag
  for (genvar k = 0; k < g_cnt_pp; k++) begin : g_cnt
    localparam int c_word = k / g_word_w;
    localparam int c_bit  = k % g_word_w;

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       ovf_q;
    logic       ovf_d;
    logic       w_inc;
    logic       w_dec;

    assign w_inc = events_i[k];
    // The accepted word carries this event only if its index and bit match
    assign w_dec = w_hs && (evt_idx_q == c_idx_w'(c_word)) && evt_q[c_bit];

    // Saturating count; a coincident increment and decrement cancel out, and a
    // new overflow takes priority over a clear in the same cycle
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (ovf_clr_i) begin
        ovf_d = 1'b0;
      end
      if (w_inc && !w_dec) begin
        if (cnt_q == 2'd3) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end else if (w_dec && !w_inc) begin
        cnt_d = cnt_q - 2'd1;
      end
    end

    // Counter and overflow registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q <= 2'd0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign w_nz[k]  = |cnt_q;
    assign w_ovf[k] = ovf_q;
  end

  // Pending-flag word selected by the scan pointer
  always_comb begin
    w_scan_word = '0;
    for (int w = 0; w < c_nwords; w++) begin
      if (ptr_q == c_idx_w'(w)) begin
        w_scan_word = w_nz[w*g_word_w +: g_word_w];
      end
    end
  end

  // Scanner FSM: idle until something is pending, scan one word per cycle,
  // hold the offered word stable until it is accepted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      evt_q     <= '0;
      evt_idx_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_any) begin
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (|w_scan_word) begin
            evt_q     <= w_scan_word;
            evt_idx_q <= ptr_q;
            valid_q   <= 1'b1;
            state_q   <= S_OFFER;
          end else begin
            ptr_q <= w_ptr_nxt;
            if (!w_any) begin
              state_q <= S_IDLE;
            end
          end
        end
        S_OFFER: begin
          if (evt_ready_i) begin
            valid_q <= 1'b0;
            ptr_q   <= w_ptr_nxt;
            state_q <= S_SCAN;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_o       = evt_q;
  assign evt_idx_o   = evt_idx_q;
  assign evt_valid_o = valid_q;
  assign ovf_o       = w_ovf;
  assign busy_o      = w_any | (state_q == S_OFFER);

endmodule
`default_nettype wire

// File: tb/tb_pstats_evt_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pstats_evt_buffer                                            |
// | Purpose  : Self-checking bench for pstats_evt_buffer (64 events, 16-bit    |
// |            words): vector table, directed corner sequences and a random    |
// |            run against a pending-count reference model.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pstats_evt_buffer;

  logic        clk;
  logic        rst_n;
  logic [63:0] events;
  logic [15:0] evt;
  logic [1:0]  idx;
  logic        valid;
  logic        ready;
  logic [63:0] ovf;
  logic        clr;
  logic        busy;

  int errors = 0;
  int checks = 0;

  pstats_evt_buffer #(.g_cnt_pp(64), .g_word_w(16)) dut (
    .rst_n_i    (rst_n),
    .clk_i      (clk),
    .events_i   (events),
    .evt_o      (evt),
    .evt_idx_o  (idx),
    .evt_valid_o(valid),
    .evt_ready_i(ready),
    .ovf_o      (ovf),
    .ovf_clr_i  (clr),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      ev;
    int               n;
    logic [3:0][1:0]  idx;
    logic [3:0][15:0] wrd;
    bit               tp;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    events = '0;
    ready  = 1'b0;
    clr    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic [63:0] ev, input int n,
                         input logic [1:0] i0, input logic [15:0] w0,
                         input logic [1:0] i1, input logic [15:0] w1,
                         input logic [1:0] i2, input logic [15:0] w2,
                         input logic [1:0] i3, input logic [15:0] w3, input bit tp);
    vt[i].ev = ev;  vt[i].n = n;  vt[i].tp = tp;
    vt[i].idx[0] = i0; vt[i].wrd[0] = w0;
    vt[i].idx[1] = i1; vt[i].wrd[1] = w1;
    vt[i].idx[2] = i2; vt[i].wrd[2] = w2;
    vt[i].idx[3] = i3; vt[i].wrd[3] = w3;
  endtask

  // Drain with ready held high; count handshakes and those carrying bit b of word w
  task automatic drain(input int w, input int b, output int nhs, output int nbit);
    int c;
    nhs  = 0;
    nbit = 0;
    ready = 1'b1;
    for (c = 0; c < 300 && (busy || valid); c++) begin
      if (valid) begin
        nhs++;
        if (idx == 2'(w) && evt[b]) nbit++;
      end
      @(negedge clk);
    end
    chk("drain_timeout_busy", {63'd0, busy}, 64'd0);
  endtask

  int          pend[64];
  bit          movf[64];

  initial begin
    int          nhs, nbit, c;
    logic [1:0]  gi[4];
    logic [15:0] gw[4];
    int          gc[4];
    logic [15:0] sw;
    logic [1:0]  si;
    bit          stale;
    logic [63:0] mo;
    bit          any, bad, hold, hs, inc, dec, drn;
    logic [15:0] pw;
    logic [1:0]  pi;
    int          gap, maxgap, n, k;

    rst_n = 1'b1; events = '0; ready = 1'b0; clr = 1'b0;

    set_vec(0, 64'h0000_0000_0002_0000, 1, 2'd1, 16'h0002, 0, 0, 0, 0, 0, 0, 1'b0);
    set_vec(1, 64'h0001_0001_0001_0001, 4, 2'd0, 16'h0001, 2'd1, 16'h0001,
            2'd2, 16'h0001, 2'd3, 16'h0001, 1'b1);
    set_vec(2, 64'h8000_0000_0000_0028, 2, 2'd0, 16'h0028, 2'd3, 16'h8000, 0, 0, 0, 0, 1'b0);
    set_vec(3, 64'h0000_0000_8000_8000, 2, 2'd0, 16'h8000, 2'd1, 16'h8000, 0, 0, 0, 0, 1'b1);
    set_vec(4, 64'hFFFF_FFFF_FFFF_FFFF, 4, 2'd0, 16'hFFFF, 2'd1, 16'hFFFF,
            2'd2, 16'hFFFF, 2'd3, 16'hFFFF, 1'b1);
    set_vec(5, 64'h0000_0300_0000_0000, 1, 2'd2, 16'h0300, 0, 0, 0, 0, 0, 0, 1'b0);

    // Reset state, then an event on the first edge after release
    rst_n = 1'b0;
    #3;
    chk("reset_async_outputs", {valid, busy, idx, evt}, 64'd0);
    chk("reset_ovf", ovf, 64'd0);
    do_reset();
    events = 64'h0000_0100_0000_0000;
    @(negedge clk);
    events = '0;
    chk("first_edge_accept_busy", {63'd0, busy}, 64'd1);
    drain(2, 8, nhs, nbit);
    chk("first_edge_word", {32'(nhs), 32'(nbit)}, {32'd1, 32'd1});

    // Table of single-pulse vectors drained with ready=1
    for (int v = 0; v < 6; v++) begin
      do_reset();
      events = vt[v].ev;
      ready  = 1'b1;
      @(negedge clk);
      events = '0;
      nhs = 0;
      for (c = 0; c < 100 && (busy || valid); c++) begin
        if (valid) begin
          if (nhs < 4) begin
            gi[nhs] = idx; gw[nhs] = evt; gc[nhs] = c;
          end
          nhs++;
        end
        @(negedge clk);
      end
      chk($sformatf("vec%0d_idle", v), {63'd0, busy}, 64'd0);
      chk($sformatf("vec%0d_count", v), 64'(nhs), 64'(vt[v].n));
      for (int j = 0; j < vt[v].n && j < nhs && j < 4; j++) begin
        chk($sformatf("vec%0d_word%0d", v, j), {46'd0, gi[j], gw[j]},
            {46'd0, vt[v].idx[j], vt[v].wrd[j]});
        if (vt[v].tp && j > 0)
          chk($sformatf("vec%0d_spacing%0d", v, j), 64'(gc[j] - gc[j-1]), 64'd2);
      end
      chk($sformatf("vec%0d_ovf", v), ovf, 64'd0);
    end

    // Latency from IDLE: capture edge, IDLE->SCAN edge, SCAN->OFFER edge
    do_reset();
    events = 64'h1;
    @(negedge clk);
    events = '0;
    chk("lat_edge1", {63'd0, valid}, 64'd0);
    @(negedge clk);
    chk("lat_edge2", {63'd0, valid}, 64'd0);
    @(negedge clk);
    chk("lat_edge3", {63'd0, valid}, 64'd1);

    // Three pulses of bit 5, long stall, then three handshakes
    do_reset();
    events = 64'h20;
    repeat (3) @(negedge clk);
    events = '0;
    repeat (20) @(negedge clk);
    chk("stall_offer", {45'd0, valid, idx, evt}, {45'd0, 1'b1, 2'd0, 16'h0020});
    drain(0, 5, nhs, nbit);
    chk("three_hs", {32'(nhs), 32'(nbit)}, {32'd3, 32'd3});
    chk("three_hs_ovf", ovf, 64'd0);

    // Four pulses overflow, drain, then clear
    do_reset();
    events = 64'h20;
    repeat (4) @(negedge clk);
    events = '0;
    chk("ovf_set", ovf, 64'h20);
    drain(0, 5, nhs, nbit);
    chk("ovf_drain", {32'(nhs), 32'(nbit)}, {32'd3, 32'd3});
    chk("ovf_sticky", ovf, 64'h20);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovf_clear", ovf, 64'd0);

    // Offered word stays put while other events arrive; coincident inc/dec
    do_reset();
    events = 64'h20;
    @(negedge clk);
    events = '0;
    for (c = 0; c < 10 && !valid; c++) @(negedge clk);
    chk("hold_offer_start", {45'd0, valid, idx, evt}, {45'd0, 1'b1, 2'd0, 16'h0020});
    sw = evt; si = idx; stale = 1'b0;
    for (int t = 0; t < 10; t++) begin
      events = {$urandom, $urandom} & ~64'h20;
      @(negedge clk);
      if (!valid || evt !== sw || idx !== si) stale = 1'b1;
    end
    chk("hold_stable", {63'd0, stale}, 64'd0);
    events = 64'h20;
    ready  = 1'b1;
    @(negedge clk);
    events = '0;
    ready  = 1'b0;
    chk("coincide_no_ovf", {63'd0, ovf[5]}, 64'd0);
    drain(0, 5, nhs, nbit);
    chk("coincide_unchanged", 64'(nbit), 64'd1);

    // Asynchronous reset in the middle of an offer
    do_reset();
    events = 64'h0000_0000_0002_0000;
    @(negedge clk);
    events = '0;
    for (c = 0; c < 10 && !valid; c++) @(negedge clk);
    chk("rst_mid_pre", {63'd0, valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_drop", {45'd0, valid, busy, idx, evt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid || busy) stale = 1'b1;
    end
    chk("rst_no_stale", {63'd0, stale}, 64'd0);

    // Random run against a pending-count model, then a final drain
    do_reset();
    for (int i = 0; i < 64; i++) begin pend[i] = 0; movf[i] = 1'b0; end
    hold = 1'b0; gap = 0; maxgap = 0; pw = '0; pi = '0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      drn = (cyc >= 3000);
      any = 1'b0;
      for (int i = 0; i < 64; i++) begin
        mo[i] = movf[i];
        if (pend[i] > 0) any = 1'b1;
      end
      chk("rnd_ovf", ovf, mo);
      chk("rnd_busy", {63'd0, busy}, {63'd0, any | valid});
      if (hold) chk("rnd_hold", {45'd0, valid, idx, evt}, {45'd0, 1'b1, pi, pw});
      if (valid) begin
        bad = 1'b0;
        for (int b = 0; b < 16; b++)
          if (evt[b] && pend[int'(idx)*16 + b] == 0) bad = 1'b1;
        chk("rnd_mask", {62'd0, (evt != 16'd0), bad}, {62'd0, 1'b1, 1'b0});
      end
      if (any && !valid) gap++; else gap = 0;
      if (gap > maxgap) maxgap = gap;
      if (drn) begin
        events = '0; ready = 1'b1; clr = 1'b0;
      end else begin
        events = '0;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
          case ($urandom_range(0, 7))
            0: k = 5;
            1: k = 17;
            2: k = 33;
            3: k = 60;
            default: k = $urandom_range(0, 63);
          endcase
          events[k] = 1'b1;
        end
        ready = ($urandom_range(0, 9) < 6);
        clr   = ($urandom_range(0, 49) == 0);
      end
      hs = valid && ready;
      for (int i = 0; i < 64; i++) begin
        inc = events[i];
        dec = hs && (int'(idx) == i / 16) && evt[i % 16];
        if (inc && !dec && pend[i] == 3) movf[i] = 1'b1;
        else if (clr) movf[i] = 1'b0;
        if (inc && !dec && pend[i] < 3) pend[i]++;
        else if (dec && !inc && pend[i] > 0) pend[i]--;
      end
      hold = valid && !ready;
      pi = idx; pw = evt;
      @(negedge clk);
    end
    any = 1'b0;
    for (int i = 0; i < 64; i++) if (pend[i] > 0) any = 1'b1;
    chk("rnd_drained", {62'd0, any, busy}, 64'd0);
    chk("rnd_max_gap_ok", {63'd0, (maxgap <= 12)}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pstats_evt_buffer.md
PSTATS_EVT_BUFFER -- requirements
Module: pstats_evt_buffer

Interface
REQ-001 SHALL have parameter g_cnt_pp, default 64: number of event inputs.
REQ-002 SHALL have parameter g_word_w, default 16: event bits per output word; g_cnt_pp SHALL be a multiple of g_word_w.
REQ-003 SHALL derive c_nwords = g_cnt_pp/g_word_w and c_idx_w = max(1, ceil(log2(c_nwords))).
REQ-004 SHALL have port rst_n_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have port clk_i  in  1  single system clock; all logic in this domain.
REQ-006 SHALL have port events_i  in  g_cnt_pp  one-cycle event pulses, bit k = event k.
REQ-007 SHALL have port evt_o  out  g_word_w  pending-event word offered downstream.
REQ-008 SHALL have port evt_idx_o  out  c_idx_w  word index of evt_o (events idx*g_word_w upward).
REQ-009 SHALL have port evt_valid_o  out  1  evt_o/evt_idx_o valid.
REQ-010 SHALL have port evt_ready_i  in  1  downstream accepts the word.
REQ-011 SHALL have port ovf_o  out  g_cnt_pp  sticky per-event overflow flags.
REQ-012 SHALL have port ovf_clr_i  in  1  one-cycle clear of all ovf_o bits.
REQ-013 SHALL have port busy_o  out  1  high when any event pending or a word is offered.

Function
REQ-014 SHALL keep one 2-bit saturating pending counter per event (range 0..3).
REQ-015 SHALL increment counter k on the clock edge where events_i[k]=1; the increment is visible on the next cycle.
REQ-016 SHALL, when counter k=3 and events_i[k]=1 with no same-cycle decrement, hold 3 and set ovf_o[k] on the next cycle.
REQ-017 SHALL clear all ovf_o when ovf_clr_i=1; a same-cycle set wins over the clear.
REQ-018 SHALL implement an FSM with states IDLE, SCAN and OFFER.
REQ-019 IDLE: the FSM SHALL move to SCAN when any pending counter is nonzero.
REQ-020 SCAN: the FSM SHALL examine one word per cycle at pointer ptr; if any bit of that word has counter>0, it SHALL register mask (bit=counter>0) into evt_o, register ptr into evt_idx_o and go to OFFER.
REQ-021 SCAN: otherwise ptr SHALL advance; if no counter is nonzero the FSM SHALL return to IDLE.
REQ-022 OFFER: evt_valid_o SHALL be 1, and evt_o and evt_idx_o SHALL stay stable until evt_valid_o=1 and evt_ready_i=1 on the same edge.
REQ-023 On handshake, each counter whose bit is set in evt_o SHALL decrement by 1, ptr SHALL advance and the FSM SHALL go to SCAN.
REQ-024 A same-cycle increment and decrement of one counter SHALL leave it unchanged, with no overflow.
REQ-025 ptr SHALL wrap from c_nwords-1 to 0 (round-robin fairness); ptr SHALL persist across IDLE.
REQ-026 Events arriving while OFFER SHALL only update counters; the offered word SHALL NOT change.
REQ-027 Minimum latency SHALL be event pulse at cycle N -> evt_valid_o=1 at cycle N+2 when FSM is in SCAN at ptr equal to that word.
REQ-028 Steady-state throughput SHALL be one accepted word per 2 cycles with evt_ready_i held 1.
REQ-029 busy_o SHALL be 1 when any counter is nonzero or the FSM is in OFFER, and SHALL be combinational from registered state.

Reset
REQ-030 On rst_n_i=0, asynchronously: all counters=0, ovf_o=0, evt_o=0, evt_idx_o=0, evt_valid_o=0, ptr=0, FSM=IDLE, busy_o=0.
REQ-031 Reset asserted mid-OFFER SHALL drop evt_valid_o immediately and discard all pending events.
REQ-032 After release, events SHALL be accepted from the first rising edge.

Verification (g_cnt_pp=64, g_word_w=16)
REQ-033 Single pulse events_i[17] with ready=1 -> exactly one word with evt_idx_o=1, evt_o=0x0002, then IDLE, busy_o=0.
REQ-034 Pulse bit 5 three times, ready=0 for 20 cycles, then ready=1 -> three handshakes with idx 0, evt_o=0x0020, ovf_o=0.
REQ-035 Pulse bit 5 four times with ready=0 -> ovf_o[5]=1; after three handshakes pending=0; ovf_clr_i pulse -> ovf_o=0.
REQ-036 Pulse bits 0, 16, 32 and 48 together, ready=1 -> indices 0,1,2,3 in that order, each evt_o=0x0001.
REQ-037 Hold ready=0 in OFFER while toggling events_i -> evt_o and evt_idx_o unchanged; a same-cycle event plus handshake on an offered bit leaves its counter unchanged.
REQ-038 Assert rst_n_i=0 during OFFER -> evt_valid_o=0 without a clock edge; no stale word after release.
